// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/aluop encodings, control bundle layout and mult/div FSM states
// shared by the ctrl_pipe control unit.
package ctrl_pkg;
    localparam int CTRL_W = 14;
    localparam int C_RWE = 0, C_DMWE = 1, C_ALUINB = 2, C_RI = 3, C_LW = 4, C_JAL = 5, C_BNE = 6;
    localparam int C_BLT = 7, C_BEX = 8, C_J = 9, C_JR = 10, C_SETX = 11, C_MUL = 12, C_DIV = 13;
    localparam logic [4:0] OP_R = 5'b00000, OP_J = 5'b00001, OP_BNE = 5'b00010, OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR = 5'b00100, OP_ADDI = 5'b00101, OP_BLT = 5'b00110, OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000, OP_SETX = 5'b10101, OP_BEX = 5'b10110;
    localparam logic [4:0] ALU_MUL = 5'b00110, ALU_DIV = 5'b00111;
    typedef enum logic {MD_IDLE = 1'b0, MD_WAIT = 1'b1} md_state_e;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from a D-stage instruction to its control bundle,
// destination register and one-hot register read set (r0 never set).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 5,
    parameter int REG_W      = 5,
    parameter int HAS_MULDIV = 1
) (
    input  logic [31:0]         insn_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic [REG_W-1:0]    rd_o,
    output logic [2**REG_W-1:0] rmask_o
);
    logic [OPCODE_W-1:0] op;
    logic [REG_W-1:0] f_rd, f_rs, f_rt;
    logic use_rs, use_rt, use_rd, use_r30;
    logic unused_bits;

    assign op          = insn_i[31 -: OPCODE_W];
    assign f_rd        = insn_i[26 -: REG_W];
    assign f_rs        = insn_i[21 -: REG_W];
    assign f_rt        = insn_i[16 -: REG_W];
    assign unused_bits = ^{insn_i[11:7], insn_i[1:0]};

    always_comb begin
        ctrl_o = '0;
        {use_rs, use_rt, use_rd, use_r30} = '0;
        case (op)
            OP_R: begin
                ctrl_o[C_RWE] = 1'b1;
                ctrl_o[C_MUL] = (HAS_MULDIV != 0) && (insn_i[6:2] == ALU_MUL);
                ctrl_o[C_DIV] = (HAS_MULDIV != 0) && (insn_i[6:2] == ALU_DIV);
                {use_rs, use_rt} = 2'b11;
            end
            OP_ADDI: begin
                {ctrl_o[C_RWE], ctrl_o[C_ALUINB], ctrl_o[C_RI]} = 3'b111;
                use_rs = 1'b1;
            end
            OP_SW: begin
                {ctrl_o[C_DMWE], ctrl_o[C_ALUINB], ctrl_o[C_RI]} = 3'b111;
                {use_rs, use_rd} = 2'b11;
            end
            OP_LW: begin
                {ctrl_o[C_RWE], ctrl_o[C_ALUINB], ctrl_o[C_RI], ctrl_o[C_LW]} = 4'b1111;
                use_rs = 1'b1;
            end
            OP_J:    ctrl_o[C_J] = 1'b1;
            OP_BNE:  begin ctrl_o[C_BNE] = 1'b1; {use_rs, use_rd} = 2'b11; end
            OP_BLT:  begin ctrl_o[C_BLT] = 1'b1; {use_rs, use_rd} = 2'b11; end
            OP_JAL:  {ctrl_o[C_RWE], ctrl_o[C_JAL]} = 2'b11;
            OP_JR:   begin ctrl_o[C_JR] = 1'b1; use_rd = 1'b1; end
            OP_SETX: {ctrl_o[C_RWE], ctrl_o[C_SETX]} = 2'b11;
            OP_BEX:  begin ctrl_o[C_BEX] = 1'b1; use_r30 = 1'b1; end
            default: ctrl_o = '0;
        endcase
        rd_o = ctrl_o[C_JAL] ? REG_W'(31) : ctrl_o[C_SETX] ? REG_W'(30) : (|ctrl_o) ? f_rd : '0;
        rmask_o = '0;
        if (use_rs) rmask_o[f_rs] = 1'b1;
        if (use_rt) rmask_o[f_rt] = 1'b1;
        if (use_rd) rmask_o[f_rd] = 1'b1;
        if (use_r30) rmask_o[30] = 1'b1;
        rmask_o[0] = 1'b0;
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control bundles through the X/M/W stage registers and
// generates load-use stalls, taken-branch flushes and the mult/div start/wait handshake.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 5,
    parameter int REG_W      = 5,
    parameter int HAS_MULDIV = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [31:0]       d_insn,
    input  logic              x_taken,
    input  logic              md_ready,
    output logic              d_stall,
    output logic              d_flush,
    output logic              md_start,
    output logic [CTRL_W-1:0] x_ctrl,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [CTRL_W-1:0] w_ctrl,
    output logic [REG_W-1:0]  x_rd,
    output logic [REG_W-1:0]  m_rd,
    output logic [REG_W-1:0]  w_rd,
    output logic              w_we
);
    logic [CTRL_W-1:0] dec_ctrl, x_ctrl_q, x_ctrl_d, m_ctrl_q, m_ctrl_d, w_ctrl_q;
    logic [REG_W-1:0] dec_rd, x_rd_q, x_rd_d, m_rd_q, m_rd_d, w_rd_q;
    logic [2**REG_W-1:0] dec_rmask;
    logic x_v_q, x_v_d, m_v_q, m_v_d, w_v_q;
    md_state_e md_q, md_d;
    logic d_ok, flush, md_x, md_hold, md_done, x_hold, load_use, take_d;

    ctrl_decode #(.OPCODE_W(OPCODE_W), .REG_W(REG_W), .HAS_MULDIV(HAS_MULDIV)) u_dec (
        .insn_i (d_insn),
        .ctrl_o (dec_ctrl),
        .rd_o   (dec_rd),
        .rmask_o(dec_rmask)
    );

    // x_hold: X keeps the mul/div; when md_ready closes the wait, X drains to M and
    // takes a bubble because D is still held that cycle.
    always_comb begin
        d_ok     = d_valid && |dec_ctrl;
        flush    = reset && x_taken;
        md_x     = x_v_q && (x_ctrl_q[C_MUL] || x_ctrl_q[C_DIV]);
        md_start = !flush && md_q == MD_IDLE && md_x;
        md_hold  = !flush && (md_start || md_q == MD_WAIT);
        md_done  = md_q == MD_WAIT && md_ready;
        x_hold   = md_hold && !md_done;
        load_use = x_v_q && x_ctrl_q[C_LW] && x_rd_q != '0 && d_ok && dec_rmask[x_rd_q];
        take_d   = !(flush || md_hold || load_use);
        d_stall  = !flush && (md_hold || load_use);
        d_flush  = flush;
        md_d     = HAS_MULDIV == 0 ? MD_IDLE : md_start ? MD_WAIT : md_done ? MD_IDLE : md_q;
        x_v_d    = x_hold ? x_v_q : take_d && d_ok;
        x_ctrl_d = x_hold ? x_ctrl_q : take_d && d_ok ? dec_ctrl : '0;
        x_rd_d   = x_hold ? x_rd_q : take_d && d_ok ? dec_rd : '0;
        m_v_d    = !x_hold && x_v_q;
        m_ctrl_d = x_hold ? '0 : x_ctrl_q;
        m_rd_d   = x_hold ? '0 : x_rd_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_q <= MD_IDLE;
            {x_v_q, x_ctrl_q, x_rd_q, m_v_q, m_ctrl_q, m_rd_q, w_v_q, w_ctrl_q, w_rd_q} <= '0;
        end else begin
            md_q <= md_d;
            {x_v_q, x_ctrl_q, x_rd_q} <= {x_v_d, x_ctrl_d, x_rd_d};
            {m_v_q, m_ctrl_q, m_rd_q} <= {m_v_d, m_ctrl_d, m_rd_d};
            {w_v_q, w_ctrl_q, w_rd_q} <= {m_v_q, m_ctrl_q, m_rd_q};
        end
    end

    assign x_ctrl = x_ctrl_q;
    assign m_ctrl = m_ctrl_q;
    assign w_ctrl = w_ctrl_q;
    assign x_rd   = x_rd_q;
    assign m_rd   = m_rd_q;
    assign w_rd   = w_rd_q;
    assign w_we   = w_v_q && w_ctrl_q[C_RWE] && w_rd_q != '0;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus randomized traffic against a behavioural
// pipeline model built from the decode table and stall/flush priority rules.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    typedef struct packed {
        logic              v;
        logic [CTRL_W-1:0] c;
        logic [4:0]        rd;
    } st_t;

    logic clock = 1'b0, reset = 1'b0, d_valid = 1'b0, x_taken = 1'b0, md_ready = 1'b0;
    logic [31:0] d_insn = '0;
    logic d_stall, d_flush, md_start, w_we;
    logic [CTRL_W-1:0] x_ctrl, m_ctrl, w_ctrl;
    logic [4:0] x_rd, m_rd, w_rd;
    int checks = 0, errors = 0;
    st_t px = '0, pm = '0, pw = '0;
    bit busy = 1'b0;
    logic [4:0] ops [12] = '{5'b00000, 5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b01000,
                             5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b10101, 5'b10110};

    ctrl_pipe #(.OPCODE_W(5), .REG_W(5), .HAS_MULDIV(1)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_insn(d_insn),
        .x_taken(x_taken), .md_ready(md_ready), .d_stall(d_stall), .d_flush(d_flush),
        .md_start(md_start), .x_ctrl(x_ctrl), .m_ctrl(m_ctrl), .w_ctrl(w_ctrl),
        .x_rd(x_rd), .m_rd(m_rd), .w_rd(w_rd), .w_we(w_we)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (reset && x_taken && (x_ctrl[C_MUL] || x_ctrl[C_DIV])) begin
            errors++;
            $display("FAIL stim_rule: x_taken=1 with mul/div in X (x_ctrl=%b), required never", x_ctrl);
        end

    function automatic logic [31:0] ins(logic [4:0] op, logic [4:0] rd, logic [4:0] rs,
                                        logic [4:0] rt, logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'd0};
    endfunction

    function automatic st_t dec(logic [31:0] i);
        st_t s;
        logic [4:0] op;
        op = i[31:27];
        s = '0;
        s.v = 1'b1;
        s.rd = i[26:22];
        case (op)
            5'b00000: begin
                s.c[C_RWE] = 1'b1;
                s.c[C_MUL] = i[6:2] == 5'b00110;
                s.c[C_DIV] = i[6:2] == 5'b00111;
            end
            5'b00101: begin s.c[C_RWE] = 1'b1; s.c[C_ALUINB] = 1'b1; s.c[C_RI] = 1'b1; end
            5'b00111: begin s.c[C_DMWE] = 1'b1; s.c[C_ALUINB] = 1'b1; s.c[C_RI] = 1'b1; end
            5'b01000: begin
                s.c[C_RWE] = 1'b1; s.c[C_ALUINB] = 1'b1; s.c[C_RI] = 1'b1; s.c[C_LW] = 1'b1;
            end
            5'b00001: s.c[C_J] = 1'b1;
            5'b00010: s.c[C_BNE] = 1'b1;
            5'b00011: begin s.c[C_RWE] = 1'b1; s.c[C_JAL] = 1'b1; s.rd = 5'd31; end
            5'b00100: s.c[C_JR] = 1'b1;
            5'b00110: s.c[C_BLT] = 1'b1;
            5'b10101: begin s.c[C_RWE] = 1'b1; s.c[C_SETX] = 1'b1; s.rd = 5'd30; end
            5'b10110: s.c[C_BEX] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic bit reads(logic [31:0] i, logic [4:0] r);
        logic [4:0] op, rdf, rs, rt;
        {op, rdf, rs, rt} = i[31:12];
        if (r == 5'd0) return 1'b0;
        case (op)
            5'b00000:                     return r == rs || r == rt;
            5'b00101, 5'b01000:           return r == rs;
            5'b00111, 5'b00010, 5'b00110: return r == rs || r == rdf;
            5'b00100:                     return r == rdf;
            5'b10110:                     return r == 5'd30;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic bit hazard();
        return px.v && px.c[C_LW] && px.rd != 5'd0 && d_valid && reads(d_insn, px.rd);
    endfunction

    function automatic bit e_start();
        return !x_taken && !busy && px.v && (px.c[C_MUL] || px.c[C_DIV]);
    endfunction

    function automatic bit e_stall();
        return !x_taken && (busy || e_start() || hazard());
    endfunction

    task automatic model_edge();
        bit s, h;
        s = e_start();
        h = hazard();
        if (!reset) begin
            px = '0; pm = '0; pw = '0; busy = 1'b0;
        end else begin
            pw = pm;
            if (x_taken) begin pm = px; px = '0; end
            else if (s) begin pm = '0; busy = 1'b1; end
            else if (busy && md_ready) begin pm = px; px = '0; busy = 1'b0; end
            else if (busy) pm = '0;
            else if (h) begin pm = px; px = '0; end
            else begin pm = px; px = d_valid ? dec(d_insn) : '0; end
        end
    endtask

    task automatic model_clear();
        px = '0; pm = '0; pw = '0; busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit dv, input logic [31:0] i, input bit tk, input bit rdy);
        d_valid = dv; d_insn = i; x_taken = tk; md_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        drive(1, ins(5'b01000, 5'd3, 5'd1, 5'd0, 5'd0), 1, 1);
        checks++;
        if ({d_stall, d_flush, md_start, w_we} !== 4'b0) begin
            errors++;
            $display("FAIL reset_comb: stall/flush/start/we=%b required 0000", {d_stall, d_flush, md_start, w_we});
        end
        step();
        step();
        checks++;
        if ({x_ctrl, m_ctrl, w_ctrl, x_rd, m_rd, w_rd} !== '0) begin
            errors++;
            $display("FAIL reset_regs: x=%h m=%h w=%h rd=%0d/%0d/%0d required all 0", x_ctrl, m_ctrl, w_ctrl, x_rd, m_rd, w_rd);
        end
        drive(0, 0, 0, 0);
        reset = 1'b1;
        model_clear();
        step();
        checks++;
        if ({x_ctrl, d_stall, md_start} !== '0) begin
            errors++;
            $display("FAIL reset_release: x_ctrl=%h stall=%b start=%b required 0", x_ctrl, d_stall, md_start);
        end
    endtask

    task automatic test_straight();
        drive(1, ins(5'b00101, 5'd1, 5'd2, 5'd0, 5'd0), 0, 0);
        step();
        drive(1, ins(5'b00111, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0);
        checks++;
        if ({x_ctrl[C_RI], x_ctrl[C_RWE], x_rd, d_stall} !== {2'b11, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL addi_x: ri=%b rwe=%b rd=%0d stall=%b required 1 1 1 0", x_ctrl[C_RI], x_ctrl[C_RWE], x_rd, d_stall);
        end
        step();
        drive(0, 0, 0, 0);
        step();
        checks++;
        if ({w_we, w_rd, m_ctrl[C_DMWE]} !== {1'b1, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL addi_w: w_we=%b w_rd=%0d m_dmwe=%b required 1 1 1", w_we, w_rd, m_ctrl[C_DMWE]);
        end
        step();
        checks++;
        if ({w_we, w_ctrl[C_DMWE]} !== 2'b01) begin
            errors++;
            $display("FAIL sw_w: w_we=%b w_dmwe=%b required 0 1", w_we, w_ctrl[C_DMWE]);
        end
    endtask

    task automatic test_load_use();
        drive(1, ins(5'b01000, 5'd3, 5'd1, 5'd0, 5'd0), 0, 0);
        step();
        drive(1, ins(5'b00000, 5'd4, 5'd3, 5'd2, 5'd0), 0, 0);
        checks++;
        if (d_stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall: d_stall=%b required 1", d_stall);
        end
        step();
        drive(1, ins(5'b00000, 5'd4, 5'd3, 5'd2, 5'd0), 0, 0);
        checks++;
        if ({d_stall, x_ctrl} !== '0) begin
            errors++;
            $display("FAIL lu_bubble: d_stall=%b x_ctrl=%h required 0 0", d_stall, x_ctrl);
        end
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        checks++;
        if ({w_we, w_rd} !== {1'b1, 5'd4}) begin
            errors++;
            $display("FAIL lu_add_w: w_we=%b w_rd=%0d required 1 4", w_we, w_rd);
        end
        drive(1, ins(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0), 0, 0);
        step();
        drive(1, ins(5'b00000, 5'd4, 5'd0, 5'd2, 5'd0), 0, 0);
        checks++;
        if (d_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_r0: d_stall=%b required 0", d_stall);
        end
        step();
        drive(0, 0, 0, 0);
        step();
        step();
    endtask

    task automatic test_flush();
        drive(1, ins(5'b00010, 5'd5, 5'd6, 5'd0, 5'd0), 0, 0);
        step();
        drive(1, ins(5'b00101, 5'd7, 5'd1, 5'd0, 5'd0), 1, 0);
        checks++;
        if ({d_flush, d_stall} !== 2'b10) begin
            errors++;
            $display("FAIL flush_d: d_flush=%b d_stall=%b required 1 0", d_flush, d_stall);
        end
        step();
        drive(0, 0, 0, 0);
        checks++;
        if ({x_ctrl, m_ctrl[C_BNE], d_flush} !== {14'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL flush_adv: x_ctrl=%h m_bne=%b d_flush=%b required 0 1 0", x_ctrl, m_ctrl[C_BNE], d_flush);
        end
        step();
        step();
    endtask

    task automatic test_muldiv();
        int stalls = 0, starts = 0;
        drive(1, ins(5'b00000, 5'd8, 5'd1, 5'd2, 5'b00110), 0, 0);
        step();
        for (int c = 0; c <= 5; c++) begin
            drive(1, ins(5'b00101, 5'd9, 5'd8, 5'd0, 5'd0), 0, c == 5);
            stalls += int'(d_stall);
            starts += int'(md_start);
            checks++;
            if ({md_start, x_ctrl[C_MUL], x_rd} !== {c == 0, 1'b1, 5'd8} || (c > 0 && m_ctrl !== '0)) begin
                errors++;
                $display("FAIL md_wait[%0d]: start=%b x_mul=%b x_rd=%0d m_ctrl=%h required %b 1 8 0", c, md_start, x_ctrl[C_MUL], x_rd, m_ctrl, c == 0);
            end
            step();
        end
        drive(1, ins(5'b00101, 5'd9, 5'd8, 5'd0, 5'd0), 0, 0);
        checks++;
        if ({m_ctrl[C_MUL], m_rd, x_ctrl, d_stall} !== {1'b1, 5'd8, 14'd0, 1'b0}) begin
            errors++;
            $display("FAIL md_done: m_mul=%b m_rd=%0d x_ctrl=%h stall=%b required 1 8 0 0", m_ctrl[C_MUL], m_rd, x_ctrl, d_stall);
        end
        checks++;
        if (stalls != 6 || starts != 1) begin
            errors++;
            $display("FAIL md_counts: stall cycles=%0d starts=%0d required 6 1", stalls, starts);
        end
        step();
        drive(0, 0, 0, 0);
        checks++;
        if (x_rd !== 5'd9) begin
            errors++;
            $display("FAIL md_next: x_rd=%0d required 9", x_rd);
        end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        drive(1, ins(5'b00000, 5'd0, 5'd1, 5'd2, 5'd0), 0, 0);
        step();
        drive(1, ins(5'b00011, 5'd5, 5'd0, 5'd0, 5'd0), 0, 0);
        step();
        drive(1, ins(5'b10101, 5'd9, 5'd0, 5'd0, 5'd0), 0, 0);
        step();
        drive(0, 0, 0, 0);
        checks++;
        if ({w_we, w_rd, w_ctrl[C_RWE]} !== {1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL r0_we: w_we=%b w_rd=%0d rwe=%b required 0 0 1", w_we, w_rd, w_ctrl[C_RWE]);
        end
        step();
        checks++;
        if ({w_we, w_rd, w_ctrl[C_JAL]} !== {1'b1, 5'd31, 1'b1}) begin
            errors++;
            $display("FAIL jal_w: w_we=%b w_rd=%0d jal=%b required 1 31 1", w_we, w_rd, w_ctrl[C_JAL]);
        end
        step();
        checks++;
        if ({w_we, w_rd, w_ctrl[C_SETX]} !== {1'b1, 5'd30, 1'b1}) begin
            errors++;
            $display("FAIL setx_w: w_we=%b w_rd=%0d setx=%b required 1 30 1", w_we, w_rd, w_ctrl[C_SETX]);
        end
    endtask

    task automatic test_reset_in_wait();
        drive(1, ins(5'b00000, 5'd8, 5'd1, 5'd2, 5'b00111), 0, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0);
        checks++;
        if ({d_stall, md_start, x_ctrl[C_DIV]} !== 3'b101) begin
            errors++;
            $display("FAIL rw_wait: stall=%b start=%b x_div=%b required 1 0 1", d_stall, md_start, x_ctrl[C_DIV]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({d_stall, d_flush, md_start, w_we, x_ctrl, m_ctrl, w_ctrl, x_rd, m_rd, w_rd} !== '0) begin
            errors++;
            $display("FAIL rw_clear: stall=%b start=%b x=%h m=%h w=%h required all 0", d_stall, md_start, x_ctrl, m_ctrl, w_ctrl);
        end
        model_clear();
        #3 reset = 1'b1;
        step();
        drive(0, 0, 0, 1);
        step();
        drive(1, ins(5'b00000, 5'd8, 5'd1, 5'd2, 5'b00110), 0, 0);
        checks++;
        if ({d_stall, md_start, x_ctrl} !== '0) begin
            errors++;
            $display("FAIL rw_ready_ignored: stall=%b start=%b x_ctrl=%h required 0", d_stall, md_start, x_ctrl);
        end
        step();
        drive(0, 0, 0, 0);
        checks++;
        if (md_start !== 1'b1) begin
            errors++;
            $display("FAIL rw_idle: md_start=%b required 1", md_start);
        end
        step();
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
        checks++;
        if ({d_stall, m_ctrl[C_MUL]} !== 2'b01) begin
            errors++;
            $display("FAIL rw_finish: stall=%b m_mul=%b required 0 1", d_stall, m_ctrl[C_MUL]);
        end
    endtask

    task automatic test_random();
        logic [31:0] i;
        logic [4:0] r1, r2, r3, alu;
        bit tk, br;
        logic [60:0] exp_v, act_v;
        for (int n = 0; n < 600; n++) begin
            r1 = $urandom_range(0, 3) == 0 ? 5'd30 : 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            r3 = 5'($urandom_range(0, 7));
            alu = $urandom_range(0, 2) == 0 ? 5'b00110 : $urandom_range(0, 2) == 0 ? 5'b00111 : 5'($urandom_range(0, 5));
            i = $urandom_range(0, 15) == 0 ? ins(5'b11111, r1, r2, r3, alu) : ins(ops[$urandom_range(0, 11)], r1, r2, r3, alu);
            br = px.v && (px.c[C_BNE] || px.c[C_BLT] || px.c[C_BEX] || px.c[C_J] || px.c[C_JR] || px.c[C_JAL]);
            tk = br && $urandom_range(0, 2) == 0;
            drive($urandom_range(0, 9) < 8, i, tk, $urandom_range(0, 3) == 0);
            exp_v = {e_stall(), x_taken, e_start(), px.c, pm.c, pw.c, px.rd, pm.rd, pw.rd,
                     pw.v && pw.c[C_RWE] && pw.rd != 5'd0};
            act_v = {d_stall, d_flush, md_start, x_ctrl, m_ctrl, w_ctrl, x_rd, m_rd, w_rd, w_we};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: dut=%h model=%h insn=%h", n, act_v, exp_v, i);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_load_use();
        test_flush();
        test_muldiv();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
